// File: rtl/wb_b3_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and its slave.
// Field names follow the master's point of view (_o driven by master, _i by slave).
interface wb_b3_burst_master_if #(
    parameter int aw = 32,
    parameter int dw = 32
);
    logic [aw-1:0] wb_adr_o;
    logic [1:0]    wb_bte_o;
    logic [2:0]    wb_cti_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [3:0]    wb_sel_o;
    logic [dw-1:0] wb_dat_o;
    logic [dw-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_rty_i;

    modport master (
        output wb_adr_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 master turning one line request into a critical-word-first wrapping burst.
// Define WB_BURST_TIMEOUT_EN to add an ack watchdog that aborts a stalled burst.
module wb_b3_burst_master #(
    parameter int aw        = 32,
    parameter int dw        = 32,
    parameter int burst_len = 4,
    parameter int timeout   = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [aw-1:0] req_adr_i,
    input  logic          req_we_i,
    input  logic [dw-1:0] wdata_i,
    output logic          wdata_pop_o,
    output logic [dw-1:0] rdata_o,
    output logic          rdata_valid_o,
    output logic [3:0]    rdata_idx_o,
    output logic          done_o,
    output logic          err_o,
    wb_b3_burst_master_if.master wb
);
    localparam int         LB        = $clog2(burst_len);
    localparam logic [1:0] BTE       = (burst_len == 16) ? 2'b11 : (burst_len == 8) ? 2'b10 : 2'b01;
    localparam logic [3:0] LAST_BEAT = 4'(burst_len - 1);

    if (!(burst_len == 4 || burst_len == 8 || burst_len == 16) || dw != 32 ||
        timeout < 1 || timeout > 255) begin : g_bad_cfg
        $error("wb_b3_burst_master: unsupported parameter combination");
    end

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_reg, state_next;
    logic [aw-1:0] adr_reg, adr_next;
    logic          we_reg, we_next;
    logic [3:0]    beat_reg, beat_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic [dw-1:0] rdata_reg, rdata_next;
    logic [3:0]    idx_reg, idx_next;
    logic          rvalid_reg, rvalid_next;
    logic          abort, ack_ok, last_beat, timeout_hit;
    logic [LB-1:0] word_inc;

`ifdef WB_BURST_TIMEOUT_EN
    logic [7:0] wdog_reg, wdog_next;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) wdog_reg <= 8'd0;
        else          wdog_reg <= wdog_next;
    end

    // Counts consecutive ack-less burst cycles; any ack or leaving BURST clears it.
    always_comb begin
        wdog_next = 8'd0;
        if (state_reg == BURST && !wb.wb_ack_i) wdog_next = wdog_reg + 8'd1;
    end

    assign timeout_hit = (state_reg == BURST) && !wb.wb_ack_i && (wdog_reg == 8'(timeout - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // err and rty take priority over a simultaneous ack; that beat is dropped.
    assign abort     = (state_reg == BURST) && (wb.wb_err_i || wb.wb_rty_i || timeout_hit);
    assign ack_ok    = (state_reg == BURST) && wb.wb_ack_i && !abort;
    assign last_beat = (beat_reg == LAST_BEAT);
    assign word_inc  = adr_reg[LB+1:2] + LB'(1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg  <= IDLE;
            adr_reg    <= '0;
            we_reg     <= 1'b0;
            beat_reg   <= 4'd0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
            idx_reg    <= 4'd0;
            rvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            adr_reg    <= adr_next;
            we_reg     <= we_next;
            beat_reg   <= beat_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            rdata_reg  <= rdata_next;
            idx_reg    <= idx_next;
            rvalid_reg <= rvalid_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        adr_next    = adr_reg;
        we_next     = we_reg;
        beat_next   = beat_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;
        rdata_next  = rdata_reg;
        idx_next    = idx_reg;
        rvalid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    adr_next   = req_adr_i & ~aw'(3);
                    we_next    = req_we_i;
                    beat_next  = 4'd0;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (abort) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (ack_ok) begin
                    beat_next = beat_reg + 4'd1;
                    // Only the word-in-line field advances, so the address wraps inside the line.
                    adr_next[LB+1:2] = word_inc;
                    if (!we_reg) begin
                        rvalid_next = 1'b1;
                        rdata_next  = wb.wb_dat_i;
                        idx_next    = beat_reg;
                    end
                    if (last_beat) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        wdata_pop_o  = 1'b0;
        wb.wb_cyc_o  = 1'b0;
        wb.wb_stb_o  = 1'b0;
        wb.wb_we_o   = 1'b0;
        wb.wb_sel_o  = 4'h0;
        wb.wb_bte_o  = 2'b00;
        wb.wb_cti_o  = 3'b000;
        wb.wb_adr_o  = adr_reg;
        wb.wb_dat_o  = wdata_i;
        case (state_reg)
            // Holding off during the done pulse guarantees an idle cycle between bursts.
            IDLE: req_ready_o = !done_reg;
            BURST: begin
                wb.wb_cyc_o = 1'b1;
                wb.wb_stb_o = 1'b1;
                wb.wb_we_o  = we_reg;
                wb.wb_sel_o = 4'hF;
                wb.wb_bte_o = BTE;
                wb.wb_cti_o = last_beat ? 3'b111 : 3'b010;
                wdata_pop_o = ack_ok && we_reg;
            end
            default: ;
        endcase
    end

    assign rdata_o       = rdata_reg;
    assign rdata_valid_o = rvalid_reg;
    assign rdata_idx_o   = idx_reg;
    assign done_o        = done_reg;
    assign err_o         = err_reg;
endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Directed bench: three master instances (4/8/16-beat lines) sharing one RAM-like slave model.
module tb_wb_b3_burst_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    int          cur = 0;
    logic        no_ack = 1'b0, gap_mode = 1'b0, err_mode = 1'b0, rty_mode = 1'b0;
    logic        gap_tgl = 1'b0;
    logic [31:0] req_adr = 32'd0;
    logic        req_we = 1'b0;
    logic [31:0] wdata;
    logic [31:0] wcnt = 32'd0;
    int          sbeat = 0;
    int          cyc_cnt = 0;
    logic [31:0] mem [64];

    logic        req_valid [3];
    logic        req_ready [3];
    logic        pop_v [3];
    logic        rvalid_v [3];
    logic        done_v [3];
    logic        errout_v [3];
    logic [31:0] rdata_v [3];
    logic [3:0]  idx_v [3];
    logic [31:0] adr_v [3];
    logic [31:0] dato_v [3];
    logic [31:0] dati_v [3];
    logic [1:0]  bte_v [3];
    logic [2:0]  cti_v [3];
    logic        cyc_v [3], stb_v [3], we_v [3];
    logic [3:0]  sel_v [3];
    logic        ack_v [3], err_v [3], rty_v [3];

    assign wdata = 32'hA0 + wcnt;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int BL = (gi == 0) ? 4 : (gi == 1) ? 8 : 16;
        wb_b3_burst_master_if #(.aw(32), .dw(32)) bus ();
        wb_b3_burst_master #(.aw(32), .dw(32), .burst_len(BL), .timeout(10)) dut (
            .wb_clk_i      (clk),
            .wb_rst_i      (rst),
            .req_valid_i   (req_valid[gi]),
            .req_ready_o   (req_ready[gi]),
            .req_adr_i     (req_adr),
            .req_we_i      (req_we),
            .wdata_i       (wdata),
            .wdata_pop_o   (pop_v[gi]),
            .rdata_o       (rdata_v[gi]),
            .rdata_valid_o (rvalid_v[gi]),
            .rdata_idx_o   (idx_v[gi]),
            .done_o        (done_v[gi]),
            .err_o         (errout_v[gi]),
            .wb            (bus)
        );
        assign adr_v[gi]        = bus.wb_adr_o;
        assign dato_v[gi]       = bus.wb_dat_o;
        assign bte_v[gi]        = bus.wb_bte_o;
        assign cti_v[gi]        = bus.wb_cti_o;
        assign cyc_v[gi]        = bus.wb_cyc_o;
        assign stb_v[gi]        = bus.wb_stb_o;
        assign we_v[gi]         = bus.wb_we_o;
        assign sel_v[gi]        = bus.wb_sel_o;
        assign bus.wb_dat_i     = dati_v[gi];
        assign bus.wb_ack_i     = ack_v[gi];
        assign bus.wb_err_i     = err_v[gi];
        assign bus.wb_rty_i     = rty_v[gi];
    end

    // Slave model: acks the selected master, optional stalls / error injection.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ack_v[k]  = (k == cur) && cyc_v[k] && stb_v[k] && !no_ack && (!gap_mode || gap_tgl);
            err_v[k]  = (k == cur) && cyc_v[k] && stb_v[k] && err_mode && (sbeat == 2);
            rty_v[k]  = (k == cur) && cyc_v[k] && stb_v[k] && rty_mode && (sbeat == 1);
            dati_v[k] = mem[adr_v[k][7:2]];
        end
    end

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        gap_tgl <= ~gap_tgl;
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
        end else if (cyc_v[cur] && ack_v[cur] && we_v[cur] && !err_v[cur] && !rty_v[cur]) begin
            mem[adr_v[cur][7:2]] <= dato_v[cur];
        end
        if (!cyc_v[cur]) begin
            sbeat <= 0;
            wcnt  <= 32'd0;
        end else begin
            if (ack_v[cur]) sbeat <= sbeat + 1;
            if (pop_v[cur]) wcnt <= wcnt + 32'd1;
        end
    end

    // Monitor: logs beats and events of the selected instance at the falling edge.
    logic [31:0] q_adr [$];
    logic [2:0]  q_cti [$];
    logic [1:0]  q_bte [$];
    logic [31:0] q_rd [$];
    logic [3:0]  q_idx [$];
    int   n_pop = 0, n_done = 0, n_err = 0, n_hold_bad = 0;
    int   last_ack_cyc = 0, done_cyc = 0, err_cyc = 0, stb_rise_cyc = 0;
    logic cyc_at_end = 1'b0, ready_at_done = 1'b0;
    logic prev_gap = 1'b0, stb_prev = 1'b0;
    logic [31:0] prev_adr = 32'd0;
    logic [2:0]  prev_cti = 3'd0;

    always @(negedge clk) begin
        if (cyc_v[cur] && stb_v[cur] && ack_v[cur] && !err_v[cur] && !rty_v[cur]) begin
            q_adr.push_back(adr_v[cur]);
            q_cti.push_back(cti_v[cur]);
            q_bte.push_back(bte_v[cur]);
            last_ack_cyc = cyc_cnt;
        end
        if (rvalid_v[cur]) begin
            q_rd.push_back(rdata_v[cur]);
            q_idx.push_back(idx_v[cur]);
        end
        if (pop_v[cur]) n_pop++;
        if (done_v[cur]) begin
            n_done++;
            done_cyc      = cyc_cnt;
            cyc_at_end    = cyc_v[cur];
            ready_at_done = req_ready[cur];
        end
        if (errout_v[cur]) begin
            n_err++;
            err_cyc    = cyc_cnt;
            cyc_at_end = cyc_v[cur];
        end
        if (stb_v[cur] && !stb_prev) stb_rise_cyc = cyc_cnt;
        if (stb_v[cur] && prev_gap && (adr_v[cur] != prev_adr || cti_v[cur] != prev_cti)) n_hold_bad++;
        prev_gap = stb_v[cur] && !ack_v[cur];
        prev_adr = adr_v[cur];
        prev_cti = cti_v[cur];
        stb_prev = stb_v[cur];
    end

    int n_checks = 0, n_pass = 0;
    int b_adr, b_rd, b_pop, b_done, b_err, b_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic start_burst(input int k, input logic [31:0] adr, input logic we);
        cur = k;
        @(negedge clk);
        b_adr = q_adr.size(); b_rd = q_rd.size(); b_pop = n_pop;
        b_done = n_done; b_err = n_err; b_hold = n_hold_bad;
        check("ready_idle", 32'(req_ready[k]), 32'd1);
        req_adr = adr; req_we = we; req_valid[k] = 1'b1;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        check("cyc_rise", 32'(cyc_v[k]), 32'd1);
        check("sel", 32'(sel_v[k]), 32'hF);
    endtask

    task automatic run_burst(input int k, input logic [31:0] adr, input logic we, input int max_cyc);
        start_burst(k, adr, we);
        for (int i = 0; i < max_cyc && (n_done + n_err == b_done + b_err); i++) @(negedge clk);
        check("burst_end", 32'(n_done + n_err - b_done - b_err), 32'd1);
        repeat (2) @(negedge clk);
        $display("burst inst=%0d adr=0x%08h we=%0b acks=%0d rdata=%0d pops=%0d done=%0d err=%0d",
                 k, adr, we, q_adr.size() - b_adr, q_rd.size() - b_rd, n_pop - b_pop,
                 n_done - b_done, n_err - b_err);
    endtask

    logic [31:0] t1_adr [4] = '{32'h18, 32'h1C, 32'h10, 32'h14};
    logic [31:0] t1_dat [4] = '{32'd6, 32'd7, 32'd4, 32'd5};

    initial begin
        for (int k = 0; k < 3; k++) req_valid[k] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cyc", 32'(cyc_v[0]), 32'd0);
        check("rst_stb", 32'(stb_v[0]), 32'd0);
        check("rst_we", 32'(we_v[0]), 32'd0);
        check("rst_cti", 32'(cti_v[0]), 32'd0);
        check("rst_adr", adr_v[0], 32'd0);
        check("rst_rdata", rdata_v[0], 32'd0);
        check("rst_idx", 32'(idx_v[0]), 32'd0);
        check("rst_rvalid", 32'(rvalid_v[0]), 32'd0);
        check("rst_done", 32'(done_v[0]), 32'd0);
        check("rst_err", 32'(errout_v[0]), 32'd0);
        check("rst_pop", 32'(pop_v[0]), 32'd0);
        check("rst_ready", 32'(req_ready[0]), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 4-beat read, critical word 0x18
        run_burst(0, 32'h18, 1'b0, 50);
        check("t1_acks", 32'(q_adr.size() - b_adr), 32'd4);
        check("t1_rds", 32'(q_rd.size() - b_rd), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_adr", q_adr[b_adr+i], t1_adr[i]);
            check("t1_cti", 32'(q_cti[b_adr+i]), (i == 3) ? 32'h7 : 32'h2);
            check("t1_bte", 32'(q_bte[b_adr+i]), 32'h1);
            check("t1_rdata", q_rd[b_rd+i], t1_dat[i]);
            check("t1_idx", 32'(q_idx[b_rd+i]), 32'(i));
        end
        check("t1_done_lat", 32'(done_cyc - last_ack_cyc), 32'd1);
        check("t1_cyc_at_done", 32'(cyc_at_end), 32'd0);
        check("t1_ready_at_done", 32'(ready_at_done), 32'd0);
        check("t1_ready_after", 32'(req_ready[0]), 32'd1);
        check("t1_done_cnt", 32'(n_done - b_done), 32'd1);

        // 8-beat write at 0x20
        run_burst(1, 32'h20, 1'b1, 50);
        check("t2_pops", 32'(n_pop - b_pop), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t2_adr", q_adr[b_adr+i], 32'h20 + 32'(4 * i));
            check("t2_bte", 32'(q_bte[b_adr+i]), 32'h2);
            check("t2_mem", mem[8+i], 32'hA0 + 32'(i));
        end

        // 8-beat read starting mid-line: wraps A3..A7, A0..A2
        run_burst(1, 32'h2E, 1'b0, 50);
        check("t2r_rds", 32'(q_rd.size() - b_rd), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t2r_rdata", q_rd[b_rd+i], 32'hA0 + 32'((3 + i) % 8));
            check("t2r_idx", 32'(q_idx[b_rd+i]), 32'(i));
        end

        // 16-beat write with ack every other cycle, critical word 33
        gap_mode = 1'b1;
        run_burst(2, 32'h84, 1'b1, 100);
        gap_mode = 1'b0;
        check("t3_pops", 32'(n_pop - b_pop), 32'd16);
        check("t3_hold", 32'(n_hold_bad - b_hold), 32'd0);
        check("t3_done", 32'(n_done - b_done), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("t3_adr", q_adr[b_adr+i], 32'h80 + 32'(4 * ((1 + i) % 16)));
            check("t3_cti", 32'(q_cti[b_adr+i]), (i == 15) ? 32'h7 : 32'h2);
            check("t3_mem", mem[32 + ((1 + i) % 16)], 32'hA0 + 32'(i));
        end

        // err (with ack) on beat 2 of a 4-beat read
        err_mode = 1'b1;
        run_burst(0, 32'h08, 1'b0, 50);
        err_mode = 1'b0;
        check("t4_err", 32'(n_err - b_err), 32'd1);
        check("t4_done", 32'(n_done - b_done), 32'd0);
        check("t4_rds", 32'(q_rd.size() - b_rd), 32'd2);
        check("t4_rd0", q_rd[b_rd], 32'd2);
        check("t4_rd1", q_rd[b_rd+1], 32'd3);
        check("t4_idx1", 32'(q_idx[b_rd+1]), 32'd1);
        check("t4_cyc_at_err", 32'(cyc_at_end), 32'd0);
        check("t4_ready_after", 32'(req_ready[0]), 32'd1);

        // rty on beat 1 of a write: only beat 0 is consumed
        rty_mode = 1'b1;
        run_burst(0, 32'h00, 1'b1, 50);
        rty_mode = 1'b0;
        check("t5_err", 32'(n_err - b_err), 32'd1);
        check("t5_pops", 32'(n_pop - b_pop), 32'd1);
        check("t5_mem0", mem[0], 32'hA0);
        check("t5_mem1", mem[1], 32'd1);

        // reset during beat 1
        start_burst(0, 32'h00, 1'b0);
        for (int i = 0; i < 20 && sbeat != 1; i++) @(negedge clk);
        check("t6_reached_beat1", 32'(sbeat), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_cyc", 32'(cyc_v[0]), 32'd0);
        check("t6_stb", 32'(stb_v[0]), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_done", 32'(n_done - b_done), 32'd0);
        check("t6_no_err", 32'(n_err - b_err), 32'd0);
        $display("burst inst=0 adr=0x00000000 we=0 interrupted by reset");
        run_burst(0, 32'h18, 1'b0, 50);
        check("t6_fresh_done", 32'(n_done - b_done), 32'd1);
        check("t6_fresh_rd0", q_rd[b_rd], 32'd6);

        // slave never acks
        no_ack = 1'b1;
`ifdef WB_BURST_TIMEOUT_EN
        run_burst(0, 32'h00, 1'b0, 40);
        check("t7_err", 32'(n_err - b_err), 32'd1);
        check("t7_err_lat", 32'(err_cyc - stb_rise_cyc), 32'd10);
        check("t7_cyc_at_err", 32'(cyc_at_end), 32'd0);
`else
        start_burst(0, 32'h00, 1'b0);
        repeat (1000) @(negedge clk);
        check("t7_cyc_held", 32'(cyc_v[0]), 32'd1);
        check("t7_no_end", 32'(n_done + n_err - b_done - b_err), 32'd0);
        $display("burst inst=0 adr=0x00000000 we=0 stalled for 1000 cycles");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        no_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
